// File: rtl/usb_rc_crc.sv
// Receive-side PID/CRC16 checker: takes one de-stuffed bit per clock (LSB-first),
// classifies the packet as handshake or data and holds a pass/fail result until acknowledged.
module usb_rc_crc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_in,
   input  logic        start_rc_crc,
   input  logic        end_rc_crc,
   input  logic        pkt_rec,
   input  logic        rc_CRCerror,
   output logic        pkt_status,
   output logic        CRC_error,
   output logic [7:0]  rc_hshake,
   output logic [63:0] rc_data
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PID,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam logic [15:0] CRC_INIT      = 16'hFFFF;
   localparam logic [15:0] CRC_POLY      = 16'h8005;
   localparam logic [15:0] CRC_RESIDUE   = 16'h800D;
   localparam logic [6:0]  CNT_MAX       = 7'd127;
   localparam logic [6:0]  PID_LAST      = 7'd7;
   localparam logic [6:0]  HSHAKE_BITS   = 7'd8;
   localparam logic [6:0]  PAYLOAD_FIRST = 7'd8;
   localparam logic [6:0]  PAYLOAD_LAST  = 7'd71;
   localparam logic [6:0]  DATA_BITS     = 7'd88;

   state_t      state_q;
   logic [6:0]  cnt_q;        // number of packet bits received so far
   logic [15:0] crc_q;
   logic [7:0]  pid_q;
   logic        err_sticky_q;
   logic        status_q;
   logic        error_q;

   logic [6:0]  cnt_next;
   logic        crc_fb;
   logic [15:0] crc_next;
   logic        pid_valid;
   logic        pid_is_hshake;
   logic        pid_is_data;
   logic        end_error;

   assign cnt_next      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 7'd1;
   assign crc_fb        = s_in ^ crc_q[15];
   assign crc_next      = {crc_q[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
   assign pid_valid     = (pid_q[7:4] == ~pid_q[3:0]);
   assign pid_is_hshake = (pid_q[1:0] == 2'b10);
   assign pid_is_data   = (pid_q[1:0] == 2'b11);

   // Verdict for a packet whose end marker is being sampled this cycle.
   always_comb begin
      // NOTE: end_error takes a default before any condition, so no path leaves it unassigned and no latch is inferred.
      end_error = err_sticky_q | rc_CRCerror;
      if (!pid_valid)
         end_error = 1'b1;
      if (!pid_is_hshake && !pid_is_data)
         end_error = 1'b1;
      if (pid_is_hshake && (cnt_q != HSHAKE_BITS))
         end_error = 1'b1;
      if (pid_is_data && ((cnt_q != DATA_BITS) || (crc_q != CRC_RESIDUE)))
         end_error = 1'b1;
   end

   // NOTE: all state here is sequential and uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 7'd0;
         crc_q        <= CRC_INIT;
         pid_q        <= 8'h00;
         err_sticky_q <= 1'b0;
         status_q     <= 1'b0;
         error_q      <= 1'b0;
         rc_hshake    <= 8'h00;
         rc_data      <= 64'h0;
      end else if (start_rc_crc) begin
         // Start in any state (even alongside end_rc_crc) restarts; this cycle carries PID bit 0.
         state_q      <= ST_PID;
         cnt_q        <= 7'd1;
         crc_q        <= CRC_INIT;
         pid_q        <= {7'b0, s_in};
         err_sticky_q <= 1'b0;
         status_q     <= 1'b0;
         error_q      <= 1'b0;
         rc_hshake    <= 8'h00;
         rc_data      <= 64'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
            end

            ST_PID, ST_DATA: begin
               err_sticky_q <= err_sticky_q | rc_CRCerror;
               if (end_rc_crc) begin
                  state_q  <= ST_DONE;
                  status_q <= 1'b1;
                  error_q  <= end_error;
                  if (state_q == ST_PID && pid_valid && pid_is_hshake && cnt_q == HSHAKE_BITS)
                     rc_hshake <= pid_q;
               end else begin
                  cnt_q <= cnt_next;
                  if (state_q == ST_PID) begin
                     if (cnt_q < HSHAKE_BITS)
                        pid_q[cnt_q[2:0]] <= s_in;
                     // Bits 0 and 1 already decide the packet type when bit 7 arrives.
                     if (cnt_q == PID_LAST && pid_is_data)
                        state_q <= ST_DATA;
                  end else begin
                     crc_q <= crc_next;
                     if (cnt_q >= PAYLOAD_FIRST && cnt_q <= PAYLOAD_LAST)
                        rc_data <= {s_in, rc_data[63:1]};
                  end
               end
            end

            ST_DONE: begin
               error_q <= error_q | rc_CRCerror;
               if (pkt_rec) begin
                  state_q  <= ST_IDLE;
                  status_q <= 1'b0;
                  error_q  <= 1'b0;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // An upstream error coinciding with the acknowledge must still show in the last valid cycle.
   assign pkt_status = status_q;
   assign CRC_error  = error_q | (status_q & rc_CRCerror);

endmodule

// File: tb/tb_usb_rc_crc.sv
// Self-checking bench for usb_rc_crc: directed scenarios plus randomized packets
// compared against a packet-level reference model.
module tb_usb_rc_crc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_in;
   logic        start_rc_crc;
   logic        end_rc_crc;
   logic        pkt_rec;
   logic        rc_CRCerror;
   logic        pkt_status;
   logic        CRC_error;
   logic [7:0]  rc_hshake;
   logic [63:0] rc_data;

   int total = 0;
   int bad   = 0;
   bit pkt_bits[$];

   always #5 clk = ~clk;

   usb_rc_crc dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_in         (s_in),
      .start_rc_crc (start_rc_crc),
      .end_rc_crc   (end_rc_crc),
      .pkt_rec      (pkt_rec),
      .rc_CRCerror  (rc_CRCerror),
      .pkt_status   (pkt_status),
      .CRC_error    (CRC_error),
      .rc_hshake    (rc_hshake),
      .rc_data      (rc_data)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] crc_over(input int first, input int last);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = first; i < last; i++) begin
         fb = pkt_bits[i] ^ c[15];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return c;
   endfunction

   task automatic build_pid(input logic [7:0] pid);
      pkt_bits.delete();
      for (int i = 0; i < 8; i++) pkt_bits.push_back(pid[i]);
   endtask

   task automatic build_data(input logic [7:0] pid, input logic [63:0] payload, input int flip);
      logic [15:0] c;
      pkt_bits.delete();
      for (int i = 0; i < 8; i++)  pkt_bits.push_back(pid[i]);
      for (int i = 0; i < 64; i++) pkt_bits.push_back(payload[i]);
      c = crc_over(8, 72);
      for (int i = 15; i >= 0; i--) pkt_bits.push_back(~c[i]);
      if (flip >= 0) pkt_bits[flip] = ~pkt_bits[flip];
   endtask

   task automatic truncate(input int n);
      while (pkt_bits.size() > n) void'(pkt_bits.pop_back());
   endtask

   task automatic model(input bit ext, output logic exp_err, output logic [7:0] exp_hs,
                        output logic [63:0] exp_data, output bit data_known);
      int         n;
      int         m;
      logic [7:0] pid;
      bit         valid, is_hs, is_data;
      n   = pkt_bits.size();
      pid = 8'h00;
      for (int i = 0; i < 8 && i < n; i++) pid[i] = pkt_bits[i];
      valid   = (pid[7:4] == ~pid[3:0]);
      is_hs   = (pid[1:0] == 2'b10);
      is_data = (pid[1:0] == 2'b11);
      exp_err = !valid || !(is_hs || is_data) || (is_hs && n != 8) ||
                (is_data && (n != 88 || crc_over(8, n) != 16'h800D)) || ext;
      exp_hs  = (is_hs && valid && n == 8) ? pid : 8'h00;
      m = is_data ? n - 8 : 0;
      if (m < 0)  m = 0;
      if (m > 64) m = 64;
      data_known = (m == 0) || (m == 64);
      exp_data   = 64'h0;
      if (m == 64)
         for (int i = 0; i < 64; i++) exp_data[i] = pkt_bits[8 + i];
   endtask

   // ---------------- drivers (called at posedge + 1) ----------------
   task automatic drive_bits(input int err_at, input bit end_with_start);
      for (int k = 0; k < pkt_bits.size(); k++) begin
         start_rc_crc = (k == 0);
         end_rc_crc   = (k == 0) && end_with_start;
         s_in         = pkt_bits[k];
         rc_CRCerror  = (k == err_at);
         @(posedge clk); #1;
      end
      start_rc_crc = 1'b0;
      end_rc_crc   = 1'b0;
      s_in         = 1'b0;
      rc_CRCerror  = 1'b0;
   endtask

   task automatic send(input int err_at, input bit end_with_start);
      drive_bits(err_at, end_with_start);
      total++;
      if (pkt_status !== 1'b0) begin
         bad++;
         $display("FAIL status_before_end: got %b expected 0", pkt_status);
      end
      end_rc_crc = 1'b1;
      @(posedge clk); #1;
      end_rc_crc = 1'b0;
   endtask

   task automatic release_pkt();
      pkt_rec = 1'b1;
      @(posedge clk); #1;
      pkt_rec = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; s_in = 1'b0; start_rc_crc = 1'b0; end_rc_crc = 1'b0;
      pkt_rec = 1'b0; rc_CRCerror = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total += 4;
      if (pkt_status !== 1'b0) begin bad++; $display("FAIL reset_status: got %b expected 0", pkt_status); end
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL reset_error: got %b expected 0", CRC_error); end
      if (rc_hshake !== 8'h00) begin bad++; $display("FAIL reset_hshake: got %h expected 00", rc_hshake); end
      if (rc_data !== 64'h0)   begin bad++; $display("FAIL reset_data: got %h expected 0", rc_data); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ack();
      build_pid(8'hD2);
      send(-1, 1'b0);
      total += 4;
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL ack_status: got %b expected 1", pkt_status); end
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL ack_error: got %b expected 0", CRC_error); end
      if (rc_hshake !== 8'hD2) begin bad++; $display("FAIL ack_hshake: got %h expected d2", rc_hshake); end
      if (rc_data !== 64'h0)   begin bad++; $display("FAIL ack_data: got %h expected 0", rc_data); end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL ack_hold: got %b expected 1", pkt_status); end
      release_pkt();
      total += 3;
      if (pkt_status !== 1'b0) begin bad++; $display("FAIL ack_release_status: got %b expected 0", pkt_status); end
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL ack_release_error: got %b expected 0", CRC_error); end
      if (rc_hshake !== 8'hD2) begin bad++; $display("FAIL ack_hshake_kept: got %h expected d2", rc_hshake); end
   endtask

   task automatic test_good_data();
      build_data(8'hC3, 64'h0706050403020100, -1);
      send(-1, 1'b0);
      total += 4;
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL data_status: got %b expected 1", pkt_status); end
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL data_error: got %b expected 0", CRC_error); end
      if (rc_data !== 64'h0706050403020100) begin bad++; $display("FAIL data_payload: got %h expected 0706050403020100", rc_data); end
      if (rc_hshake !== 8'h00) begin bad++; $display("FAIL data_hshake: got %h expected 00", rc_hshake); end
      release_pkt();
      total += 2;
      if (pkt_status !== 1'b0) begin bad++; $display("FAIL data_release: got %b expected 0", pkt_status); end
      if (rc_data !== 64'h0706050403020100) begin bad++; $display("FAIL data_stable: got %h expected 0706050403020100", rc_data); end
   endtask

   task automatic test_corrupt();
      build_data(8'hC3, 64'h0706050403020100, 8 + 13);
      send(-1, 1'b0);
      total += 3;
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL corrupt_status: got %b expected 1", pkt_status); end
      if (CRC_error !== 1'b1)  begin bad++; $display("FAIL corrupt_error: got %b expected 1", CRC_error); end
      if (rc_data !== 64'h0706050403022100) begin bad++; $display("FAIL corrupt_payload: got %h expected 0706050403022100", rc_data); end
      release_pkt();
   endtask

   task automatic test_short();
      build_data(8'hC3, 64'h0706050403020100, -1);
      truncate(48);
      send(-1, 1'b0);
      total += 2;
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL short_status: got %b expected 1", pkt_status); end
      if (CRC_error !== 1'b1)  begin bad++; $display("FAIL short_error: got %b expected 1", CRC_error); end
      release_pkt();
   endtask

   task automatic test_bad_pid();
      build_pid(8'hC4);
      send(-1, 1'b0);
      total += 3;
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL badpid_status: got %b expected 1", pkt_status); end
      if (CRC_error !== 1'b1)  begin bad++; $display("FAIL badpid_error: got %b expected 1", CRC_error); end
      if (rc_hshake !== 8'h00) begin bad++; $display("FAIL badpid_hshake: got %h expected 00", rc_hshake); end
      release_pkt();
   endtask

   task automatic test_abort();
      build_data(8'hC3, {$urandom, $urandom}, -1);
      truncate(30);
      drive_bits(-1, 1'b0);
      build_pid(8'hD2);
      send(-1, 1'b0);
      total += 3;
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL abort_error: got %b expected 0", CRC_error); end
      if (rc_hshake !== 8'hD2) begin bad++; $display("FAIL abort_hshake: got %h expected d2", rc_hshake); end
      if (rc_data !== 64'h0)   begin bad++; $display("FAIL abort_data: got %h expected 0", rc_data); end
      release_pkt();
   endtask

   task automatic test_start_end_together();
      build_data(8'hC3, {$urandom, $urandom}, -1);
      truncate(40);
      drive_bits(-1, 1'b0);
      build_pid(8'hD2);
      send(-1, 1'b1);
      total += 3;
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL startend_status: got %b expected 1", pkt_status); end
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL startend_error: got %b expected 0", CRC_error); end
      if (rc_hshake !== 8'hD2) begin bad++; $display("FAIL startend_hshake: got %h expected d2", rc_hshake); end
      release_pkt();
   endtask

   task automatic test_ext_error();
      build_data(8'hC3, 64'h0706050403020100, -1);
      send(50, 1'b0);
      total += 2;
      if (CRC_error !== 1'b1) begin bad++; $display("FAIL ext_error: got %b expected 1", CRC_error); end
      if (rc_data !== 64'h0706050403020100) begin bad++; $display("FAIL ext_payload: got %h expected 0706050403020100", rc_data); end
      release_pkt();
      build_pid(8'hD2);
      send(-1, 1'b0);
      total++;
      if (CRC_error !== 1'b0) begin bad++; $display("FAIL ext_cleared: got %b expected 0", CRC_error); end
      rc_CRCerror = 1'b1;
      @(posedge clk); #1;
      rc_CRCerror = 1'b0;
      @(posedge clk); #1;
      total += 2;
      if (CRC_error !== 1'b1)  begin bad++; $display("FAIL done_ext_error: got %b expected 1", CRC_error); end
      if (pkt_status !== 1'b1) begin bad++; $display("FAIL done_ext_status: got %b expected 1", pkt_status); end
      release_pkt();
      total += 2;
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL done_ext_release_err: got %b expected 0", CRC_error); end
      if (pkt_status !== 1'b0) begin bad++; $display("FAIL done_ext_release_status: got %b expected 0", pkt_status); end
   endtask

   task automatic test_reset_mid();
      build_data(8'hC3, 64'hFFFF_FFFF_FFFF_FFFF, -1);
      truncate(40);
      drive_bits(-1, 1'b0);
      rst_n = 1'b0;
      #2;
      total += 4;
      if (pkt_status !== 1'b0) begin bad++; $display("FAIL midrst_status: got %b expected 0", pkt_status); end
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL midrst_error: got %b expected 0", CRC_error); end
      if (rc_hshake !== 8'h00) begin bad++; $display("FAIL midrst_hshake: got %h expected 00", rc_hshake); end
      if (rc_data !== 64'h0)   begin bad++; $display("FAIL midrst_data: got %h expected 0", rc_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      build_pid(8'hD2);
      send(-1, 1'b0);
      total += 2;
      if (rc_hshake !== 8'hD2) begin bad++; $display("FAIL midrst_recover_hshake: got %h expected d2", rc_hshake); end
      if (CRC_error !== 1'b0)  begin bad++; $display("FAIL midrst_recover_error: got %b expected 0", CRC_error); end
      release_pkt();
   endtask

   task automatic test_random();
      logic        exp_err;
      logic [7:0]  exp_hs;
      logic [63:0] exp_data;
      logic [63:0] pay;
      logic [3:0]  nib;
      bit          dk;
      int          kind;
      int          err_at;
      int          target;
      for (int t = 0; t < 40; t++) begin
         kind   = $urandom_range(0, 5);
         pay    = {$urandom, $urandom};
         err_at = -1;
         case (kind)
            0: begin nib = {2'($urandom), 2'b10}; build_pid({~nib, nib}); end
            1: build_pid(8'($urandom));
            2: begin nib = {2'($urandom), 2'b11}; build_data({~nib, nib}, pay, -1); end
            3: begin nib = {2'($urandom), 2'b11}; build_data({~nib, nib}, pay, $urandom_range(8, 87)); end
            4: begin nib = {2'($urandom), 2'b11}; build_data({~nib, nib}, pay, -1); err_at = $urandom_range(1, 87); end
            default: begin
               nib = {2'($urandom), 2'b11};
               build_data({~nib, nib}, pay, -1);
               target = $urandom_range(72, 100);
               truncate(target);
               while (pkt_bits.size() < target) pkt_bits.push_back(1'($urandom));
            end
         endcase
         model(err_at >= 1, exp_err, exp_hs, exp_data, dk);
         send(err_at, 1'b0);
         total += 3;
         if (pkt_status !== 1'b1) begin bad++; $display("FAIL rand%0d_status: got %b expected 1", t, pkt_status); end
         if (CRC_error !== exp_err) begin bad++; $display("FAIL rand%0d_error: got %b expected %b (kind %0d)", t, CRC_error, exp_err, kind); end
         if (rc_hshake !== exp_hs) begin bad++; $display("FAIL rand%0d_hshake: got %h expected %h", t, rc_hshake, exp_hs); end
         if (dk) begin
            total++;
            if (rc_data !== exp_data) begin bad++; $display("FAIL rand%0d_data: got %h expected %h", t, rc_data, exp_data); end
         end
         release_pkt();
      end
   endtask

   initial begin
      test_reset();
      test_ack();
      test_good_data();
      test_corrupt();
      test_short();
      test_bad_pid();
      test_abort();
      test_start_end_together();
      test_ext_error();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
